// File: rtl/alu_frame_sequencer.sv
// alu_frame_sequencer: collects A/B/opcode bytes, holds them for the ALU and hands the result to the transmitter
//   in : clk, reset (sync, active high), rx_data/rx_done (receiver), alu_result (combinational ALU), tx_busy
//   out: alu_a/alu_b/alu_op (held operands), tx_data/tx_start (transmitter), frame_err (timeout pulse), overrun (sticky)
module alu_frame_sequencer #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] CALC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;
  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [7:0]        txd_q, txd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ferr_q, ferr_d, ovr_q, ovr_d, first_q, first_d;
  logic              tmo, busy_state;
  assign tmo        = cnt_q == CW'(TIMEOUT - 1);
  assign busy_state = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);
  assign tx_start   = (state_q == SEND) && !tx_busy;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign tx_data    = txd_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  // A byte arriving in the same cycle as the timeout is accepted: rx_done is tested before tmo.
  // first_q marks the first WAIT_TX cycle, which ignores tx_busy so the transmitter has time to raise it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    txd_d   = txd_q;
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q | (rx_done && busy_state);
    first_d = 1'b0;
    case (state_q)
      WAIT_A: if (rx_done) begin
        a_d     = DATA_W'(rx_data);
        cnt_d   = '0;
        state_d = WAIT_B;
      end
      WAIT_B: if (rx_done) begin
        b_d     = DATA_W'(rx_data);
        cnt_d   = '0;
        state_d = WAIT_OP;
      end else if (tmo) begin
        ferr_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_A;
      end else cnt_d = cnt_q + 1'b1;
      WAIT_OP: if (rx_done) begin
        op_d    = rx_data[OP_W-1:0];
        cnt_d   = '0;
        state_d = CALC;
      end else if (tmo) begin
        ferr_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_A;
      end else cnt_d = cnt_q + 1'b1;
      CALC: begin
        txd_d   = 8'(alu_result);
        state_d = SEND;
      end
      SEND: if (!tx_busy) begin
        first_d = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: state_d = (!first_q && !tx_busy) ? WAIT_A : WAIT_TX;
      default: state_d = WAIT_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      txd_q   <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      first_q <= first_d;
    end
  end
endmodule

// File: tb/tb_alu_frame_sequencer.sv
// tb_alu_frame_sequencer: directed plus randomized commands against a byte-level reference of the sequencer
module tb_alu_frame_sequencer;
  localparam int TMO = 16;
  localparam logic [5:0] OP_ADD = 6'b100000, OP_SUB = 6'b100010, OP_AND = 6'b100100, OP_OR = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110, OP_SRA = 6'b000011, OP_SRL = 6'b000010, OP_NOR = 6'b100111;
  logic       clk = 1'b0, reset = 1'b1, rx_done = 1'b0, tx_start, tx_busy, frame_err, overrun;
  logic [7:0] rx_data = 8'h00, alu_a, alu_b, alu_result, tx_data;
  logic [5:0] alu_op;
  int vectors = 0, miscompares = 0;
  int busy_cnt = 0, tx_len = 3, n_start = 0, n_ferr = 0, dbl = 0;
  logic force_busy = 1'b0, ts_prev = 1'b0, fe_prev = 1'b0;
  logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  alu_frame_sequencer #(.DATA_W(8), .OP_W(6), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_err(frame_err), .overrun(overrun));

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SRA: return 8'($signed(a) >>> b);
      OP_SRL: return a >> b;
      OP_NOR: return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) busy_cnt <= tx_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (tx_start) n_start <= n_start + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if ((tx_start && ts_prev) || (frame_err && fe_prev)) dbl <= dbl + 1;
    ts_prev <= tx_start;
    fe_prev <= frame_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 100) begin
      tick();
      n++;
    end
    check("tx_idle_bound", 32'(n < 100), 1);
    tick();
    tick();
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op, input bit ovr);
    logic [7:0] e;
    int n0;
    e = alu_ref(a, b, op);
    n0 = n_start;
    send_byte(a);
    repeat ($urandom_range(0, 4)) tick();
    check("alu_a", alu_a, a);
    send_byte(b);
    repeat ($urandom_range(0, 4)) tick();
    check("alu_b", alu_b, b);
    send_byte({2'b00, op});
    check("alu_op", alu_op, op);
    check("calc_no_start", tx_start, 0);
    tick();
    check("tx_start_t2", tx_start, 1);
    check("tx_data", tx_data, e);
    tick();
    check("tx_start_once", tx_start, 0);
    if (ovr) begin
      send_byte(8'hAA);
      check("overrun_set", overrun, 1);
      check("overrun_alu_a", alu_a, a);
    end
    wait_idle();
    check("start_count", n_start - n0, 1);
  endtask

  initial begin
    int nf;
    // reset wins over a simultaneous byte
    rx_data = 8'h55;
    rx_done = 1'b1;
    tick();
    tick();
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rx_done = 1'b0;
    reset = 1'b0;
    tick();
    // basic SRA
    run_cmd(8'h80, 8'h02, OP_SRA, 1'b0);
    check("sra_result", tx_data, 8'hE0);
    // randomized commands
    for (int i = 0; i < 8; i++)
      run_cmd(8'($urandom), 8'($urandom_range(0, 10)), ops[$urandom_range(0, 7)], 1'b0);
    // busy transmitter holds SEND
    nf = n_start;
    force_busy = 1'b1;
    send_byte(8'h0F);
    send_byte(8'h33);
    send_byte({2'b00, OP_AND});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("busy_no_start", tx_start, 0);
      check("busy_tx_data", tx_data, 8'h03);
    end
    force_busy = 1'b0;
    #1;
    check("busy_release_start", tx_start, 1);
    tick();
    check("busy_release_once", tx_start, 0);
    wait_idle();
    check("busy_start_count", n_start - nf, 1);
    // inter-byte timeout in WAIT_B
    nf = n_ferr;
    send_byte(8'h12);
    for (int i = 1; i < TMO; i++) begin
      tick();
      check("tmo_early", frame_err, 0);
    end
    tick();
    check("tmo_pulse", frame_err, 1);
    check("tmo_alu_a_kept", alu_a, 8'h12);
    tick();
    check("tmo_pulse_end", frame_err, 0);
    check("tmo_count", n_ferr - nf, 1);
    run_cmd(8'h05, 8'h01, OP_ADD, 1'b0);
    check("tmo_add_result", tx_data, 8'h06);
    // byte arriving on the timeout cycle of WAIT_OP wins
    nf = n_ferr;
    send_byte(8'hC3);
    send_byte(8'h3C);
    repeat (TMO - 1) tick();
    send_byte({2'b00, OP_OR});
    check("tie_no_ferr", frame_err, 0);
    check("tie_alu_op", alu_op, OP_OR);
    tick();
    check("tie_tx_start", tx_start, 1);
    check("tie_tx_data", tx_data, 8'hFF);
    tick();
    wait_idle();
    check("tie_ferr_count", n_ferr - nf, 0);
    // overrun during WAIT_TX, then a normal command
    run_cmd(8'h9A, 8'h0F, OP_XOR, 1'b1);
    check("overrun_sticky", overrun, 1);
    run_cmd(8'h10, 8'h20, OP_SUB, 1'b0);
    check("after_ovr_result", tx_data, 8'hF0);
    check("overrun_still", overrun, 1);
    // reset mid-frame
    nf = n_ferr;
    send_byte(8'h77);
    send_byte(8'h66);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_alu_a", alu_a, 0);
    check("mid_alu_b", alu_b, 0);
    check("mid_alu_op", alu_op, 0);
    check("mid_tx_data", tx_data, 0);
    check("mid_overrun", overrun, 0);
    check("mid_frame_err", frame_err, 0);
    run_cmd(8'h0C, 8'h0A, OP_NOR, 1'b0);
    check("mid_ferr_count", n_ferr - nf, 0);
    check("no_double_pulse", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
